// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the program-counter sequencer.
//   seq_state_t      - sequencer state: IDLE, RUN, HALT.
//   RAS_DEPTH_DEFAULT- default return-address stack depth.
//   RAS_PTR_W        - pointer width for the default stack depth.
//   ras_ptr_width()  - pointer width for an arbitrary (power-of-2) depth.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } seq_state_t;

    localparam int RAS_DEPTH_DEFAULT = 4;
    localparam int RAS_PTR_W         = $clog2(RAS_DEPTH_DEFAULT);

    function automatic int ras_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clk, reset  - clock, asynchronous active-high reset (clears pointer/count).
//   clear       - synchronous empty (contents left as-is, count forced to 0).
//   push/pop    - mutually exclusive; push while full overwrites the oldest entry.
//   push_data   - value pushed.
//   top_data    - most recently pushed live entry (combinational read).
//   empty/full  - occupancy flags.
module pc_ras
    import pc_seq_pkg::*;
#(
    parameter int D     = 12,
    parameter int DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [D-1:0] push_data,
    output logic [D-1:0] top_data,
    output logic         empty,
    output logic         full
);

    localparam int PW = ras_ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [D-1:0]  mem_q [DEPTH];
    // ptr_q is the next slot to write; with a power-of-2 depth it wraps
    // naturally, which is what makes overflow overwrite the oldest entry.
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] top_idx;

    assign top_idx  = ptr_q - PW'(1);
    assign top_data = mem_q[top_idx];
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if (clear) begin
            ptr_d   = '0;
            count_d = '0;
        end else if (push) begin
            ptr_d = ptr_q + PW'(1);
            if (!full) begin
                count_d = count_q + CW'(1);
            end
        end else if (pop && !empty) begin
            ptr_d   = top_idx;
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push && !clear && !reset) begin
            mem_q[ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: decides each cycle whether the PC increments, holds or loads.
//   clk, reset              - clock, asynchronous active-high reset.
//   start, start_addr       - begin/restart execution at start_addr.
//   pc_in                   - current PC value fed back.
//   stall, halt             - hold this cycle / stop (enter HALT).
//   br_taken, br_rel,
//   br_offset, br_addr      - relative or absolute branch.
//   call, ret               - push pc_in+1 and jump / pop and jump.
//   jump_en, target         - load request to the PC (combinational).
//   running, done           - state is RUN / HALT.
//   ras_err                 - sticky stack overflow/underflow flag.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int D         = 12,
    parameter int RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [D-1:0] start_addr,
    input  logic [D-1:0] pc_in,
    input  logic         stall,
    input  logic         halt,
    input  logic         br_taken,
    input  logic         br_rel,
    input  logic [D-1:0] br_offset,
    input  logic [D-1:0] br_addr,
    input  logic         call,
    input  logic         ret,
    output logic         jump_en,
    output logic [D-1:0] target,
    output logic         running,
    output logic         done,
    output logic         ras_err
);

    seq_state_t   state_q, state_d;
    logic         ras_err_q, ras_err_d;
    logic         ras_clear, ras_push, ras_pop;
    logic         ras_empty, ras_full;
    logic [D-1:0] ras_top;
    logic [D-1:0] ret_addr;
    logic [D-1:0] rel_target;
    logic         jump_d;
    logic [D-1:0] target_d;

    assign ret_addr   = pc_in + D'(1);
    // Two's-complement add: a negative offset wraps to a backward branch.
    assign rel_target = pc_in + br_offset;

    // The PC has no hold input, so "hold" is jump_en=1 with target=pc_in;
    // that is the default and only the increment case clears jump_d.
    always_comb begin
        state_d   = state_q;
        ras_err_d = ras_err_q;
        ras_clear = 1'b0;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        jump_d    = 1'b1;
        target_d  = pc_in;
        if (start) begin
            target_d  = start_addr;
            state_d   = RUN;
            ras_clear = 1'b1;
            ras_err_d = 1'b0;
        end else if (state_q == RUN) begin
            if (halt) begin
                state_d = HALT;
            end else if (!stall) begin
                if (ret) begin
                    if (!ras_empty) begin
                        ras_pop  = 1'b1;
                        target_d = ras_top;
                    end else begin
                        ras_err_d = 1'b1;
                        state_d   = HALT;
                    end
                end else if (call) begin
                    ras_push = 1'b1;
                    target_d = br_addr;
                    if (ras_full) begin
                        ras_err_d = 1'b1;
                    end
                end else if (br_taken) begin
                    target_d = br_rel ? rel_target : br_addr;
                end else begin
                    jump_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ras_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ras_err_q <= ras_err_d;
        end
    end

    pc_ras #(
        .D     (D),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .clear     (ras_clear),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (ret_addr),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    // Outputs are forced to their idle values for as long as reset is high.
    assign jump_en = reset ? 1'b0 : jump_d;
    assign target  = reset ? '0   : target_d;
    assign running = !reset && (state_q == RUN);
    assign done    = !reset && (state_q == HALT);
    assign ras_err = ras_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int D     = 12;
    localparam int DEPTH = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start, stall, halt, br_taken, br_rel, call, ret;
    logic [D-1:0] start_addr, pc_in, br_offset, br_addr;
    logic         jump_en, running, done, ras_err;
    logic [D-1:0] target;

    always #5 clk = ~clk;

    pc_sequencer #(.D(D), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .pc_in(pc_in), .stall(stall), .halt(halt), .br_taken(br_taken),
        .br_rel(br_rel), .br_offset(br_offset), .br_addr(br_addr),
        .call(call), .ret(ret), .jump_en(jump_en), .target(target),
        .running(running), .done(done), .ras_err(ras_err)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: state number, return addresses as a queue (back = top).
    int           m_state, nxt_state;
    logic [D-1:0] m_ras[$];
    logic [D-1:0] nxt_ras[$];
    logic         m_err, nxt_err;
    logic         exp_jump, exp_run, exp_done;
    logic [D-1:0] exp_tgt;
    logic [D-1:0] pc;

    task automatic clear_inputs();
        start = 0; halt = 0; stall = 0; br_taken = 0; br_rel = 0; call = 0; ret = 0;
        start_addr = '0; br_offset = '0; br_addr = '0;
    endtask

    task automatic model_reset();
        m_state = M_IDLE; m_ras.delete(); m_err = 0;
    endtask

    task automatic set_pc(input logic [D-1:0] v);
        pc = v; pc_in = v;
    endtask

    task automatic eval_model();
        int s;
        nxt_state = m_state; nxt_ras = m_ras; nxt_err = m_err;
        exp_jump = 1; exp_tgt = pc_in;
        exp_run = (m_state == M_RUN); exp_done = (m_state == M_HALT);
        if (start) begin
            exp_tgt = start_addr; nxt_state = M_RUN; nxt_ras.delete(); nxt_err = 0;
        end else if (m_state == M_RUN) begin
            if (halt) nxt_state = M_HALT;
            else if (stall) exp_jump = 1;
            else if (ret) begin
                if (nxt_ras.size() > 0) exp_tgt = nxt_ras.pop_back();
                else begin nxt_err = 1; nxt_state = M_HALT; end
            end else if (call) begin
                if (nxt_ras.size() == DEPTH) begin
                    void'(nxt_ras.pop_front());
                    nxt_err = 1;
                end
                s = (int'(pc_in) + 1) % (1 << D);
                nxt_ras.push_back(s[D-1:0]);
                exp_tgt = br_addr;
            end else if (br_taken) begin
                if (br_rel) begin
                    s = int'(pc_in) + int'($signed(br_offset));
                    s = ((s % (1 << D)) + (1 << D)) % (1 << D);
                    exp_tgt = s[D-1:0];
                end else exp_tgt = br_addr;
            end else exp_jump = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        m_state = nxt_state; m_ras = nxt_ras; m_err = nxt_err;
        if (exp_jump) pc = exp_tgt; else pc = pc + 1'b1;
        @(negedge clk);
        pc_in = pc;
    endtask

    task automatic test_reset();
        reset = 1; clear_inputs();
        start = 1; start_addr = 12'h123; set_pc(12'h456); call = 1;
        #2;
        checks++;
        if (jump_en !== 0 || target !== 0 || running !== 0 || done !== 0 || ras_err !== 0) begin
            failures++;
            $display("FAIL reset_outputs jump_en=%b target=%h running=%b done=%b ras_err=%b required 0 000 0 0 0",
                     jump_en, target, running, done, ras_err);
        end
        @(posedge clk); @(negedge clk);
        reset = 0; clear_inputs(); model_reset(); set_pc(12'h456);
        eval_model(); #1;
        checks++;
        if (jump_en !== 1 || target !== 12'h456 || running !== 0 || done !== 0) begin
            failures++;
            $display("FAIL idle_hold jump_en=%b target=%h running=%b done=%b required 1 456 0 0",
                     jump_en, target, running, done);
        end
        $display("reset: idle hold target=%h", target);
        step();
    endtask

    task automatic test_start();
        start = 1; start_addr = 12'h040;
        eval_model(); #1;
        checks++;
        if (jump_en !== 1 || target !== 12'h040) begin
            failures++;
            $display("FAIL start_jump jump_en=%b target=%h required 1 040", jump_en, target);
        end
        step(); start = 0;
        for (int k = 0; k < 2; k++) begin
            eval_model(); #1;
            checks++;
            if (running !== 1 || jump_en !== 0) begin
                failures++;
                $display("FAIL start_count pc=%h running=%b jump_en=%b required 1 0", pc_in, running, jump_en);
            end
            $display("start: pc=%h jump_en=%b running=%b", pc_in, jump_en, running);
            step();
        end
    endtask

    task automatic test_branch();
        set_pc(12'h050); br_taken = 1; br_rel = 1; br_offset = 12'hFFC;
        eval_model(); #1;
        checks++;
        if (jump_en !== 1 || target !== 12'h04C) begin
            failures++;
            $display("FAIL br_rel_back jump_en=%b target=%h required 1 04c", jump_en, target);
        end
        step();
        set_pc(12'hFFE); br_offset = 12'h004;
        eval_model(); #1;
        checks++;
        if (jump_en !== 1 || target !== 12'h002) begin
            failures++;
            $display("FAIL br_rel_wrap jump_en=%b target=%h required 1 002", jump_en, target);
        end
        step();
        br_rel = 0; br_addr = 12'h3A5;
        eval_model(); #1;
        checks++;
        if (jump_en !== 1 || target !== 12'h3A5) begin
            failures++;
            $display("FAIL br_abs jump_en=%b target=%h required 1 3a5", jump_en, target);
        end
        $display("branch: absolute target=%h", target);
        step(); clear_inputs();
    endtask

    task automatic test_call_ret();
        set_pc(12'h010); call = 1; br_addr = 12'h200;
        eval_model(); #1;
        checks++;
        if (jump_en !== 1 || target !== 12'h200) begin
            failures++;
            $display("FAIL call_jump jump_en=%b target=%h required 1 200", jump_en, target);
        end
        step(); call = 0;
        set_pc(12'h205); ret = 1;
        eval_model(); #1;
        checks++;
        if (jump_en !== 1 || target !== 12'h011 || ras_err !== 0) begin
            failures++;
            $display("FAIL ret_jump jump_en=%b target=%h ras_err=%b required 1 011 0", jump_en, target, ras_err);
        end
        $display("call_ret: ret target=%h", target);
        step(); ret = 0;
    endtask

    task automatic test_overflow();
        logic [D-1:0] want;
        start = 1; start_addr = 12'h300; eval_model(); step(); start = 0;
        for (int k = 0; k < 5; k++) begin
            set_pc(D'(12'h110 * (k + 1))); call = 1; br_addr = D'(12'h600 + k);
            eval_model(); #1;
            checks++;
            if (jump_en !== 1 || target !== br_addr || ras_err !== 0) begin
                failures++;
                $display("FAIL ovf_call%0d jump_en=%b target=%h ras_err=%b required 1 %h 0",
                         k, jump_en, target, ras_err, br_addr);
            end
            step();
        end
        call = 0;
        for (int k = 0; k < 4; k++) begin
            want = D'(12'h110 * (5 - k) + 1);
            set_pc(D'(12'h700 + k)); ret = 1;
            eval_model(); #1;
            checks++;
            if (jump_en !== 1 || target !== want || ras_err !== 1) begin
                failures++;
                $display("FAIL ovf_ret%0d jump_en=%b target=%h ras_err=%b required 1 %h 1",
                         k, jump_en, target, ras_err, want);
            end
            $display("overflow: ret %0d target=%h", k, target);
            step();
        end
        set_pc(12'h7F0);
        eval_model(); #1;
        checks++;
        if (jump_en !== 1 || target !== 12'h7F0) begin
            failures++;
            $display("FAIL underflow_hold jump_en=%b target=%h required 1 7f0", jump_en, target);
        end
        step(); ret = 0;
        eval_model(); #1;
        checks++;
        if (done !== 1 || running !== 0 || ras_err !== 1) begin
            failures++;
            $display("FAIL underflow_halt done=%b running=%b ras_err=%b required 1 0 1", done, running, ras_err);
        end
        step();
    endtask

    task automatic test_stall_halt();
        start = 1; start_addr = 12'h020; eval_model(); step(); start = 0;
        set_pc(12'h030); stall = 1; call = 1; br_addr = 12'h400;
        eval_model(); #1;
        checks++;
        if (jump_en !== 1 || target !== 12'h030) begin
            failures++;
            $display("FAIL stall_call jump_en=%b target=%h required 1 030", jump_en, target);
        end
        step(); stall = 0; call = 0;
        // A ret now must underflow if the stalled call pushed nothing.
        ret = 1; eval_model(); #1;
        checks++;
        if (jump_en !== 1 || target !== 12'h030) begin
            failures++;
            $display("FAIL stall_nopush jump_en=%b target=%h required 1 030", jump_en, target);
        end
        step(); ret = 0;
        eval_model(); #1;
        checks++;
        if (done !== 1 || ras_err !== 1) begin
            failures++;
            $display("FAIL stall_nopush_err done=%b ras_err=%b required 1 1", done, ras_err);
        end
        step();
        start = 1; eval_model(); step(); start = 0;
        halt = 1; eval_model(); #1;
        checks++;
        if (jump_en !== 1 || target !== pc_in) begin
            failures++;
            $display("FAIL halt_hold jump_en=%b target=%h required 1 %h", jump_en, target, pc_in);
        end
        step(); halt = 0;
        for (int k = 0; k < 3; k++) begin
            eval_model(); #1;
            checks++;
            if (done !== 1 || jump_en !== 1 || target !== 12'h020) begin
                failures++;
                $display("FAIL halted%0d done=%b jump_en=%b target=%h required 1 1 020", k, done, jump_en, target);
            end
            $display("halt: cycle %0d done=%b target=%h", k, done, target);
            step();
        end
        start = 1; start_addr = 12'h0A0; eval_model(); #1;
        checks++;
        if (jump_en !== 1 || target !== 12'h0A0) begin
            failures++;
            $display("FAIL restart jump_en=%b target=%h required 1 0a0", jump_en, target);
        end
        step(); start = 0;
        eval_model(); #1;
        checks++;
        if (running !== 1 || done !== 0 || ras_err !== 0) begin
            failures++;
            $display("FAIL restart_run running=%b done=%b ras_err=%b required 1 0 0", running, done, ras_err);
        end
        step();
    endtask

    task automatic test_async_reset();
        start = 1; start_addr = 12'h000; eval_model(); step(); start = 0;
        for (int k = 0; k < 5; k++) begin
            call = 1; br_addr = D'(12'h100 * k); eval_model(); step();
        end
        set_pc(12'h050); br_addr = 12'h123;
        eval_model(); #1;
        checks++;
        if (jump_en !== 1 || target !== 12'h123 || ras_err !== 1) begin
            failures++;
            $display("FAIL pre_reset_call jump_en=%b target=%h ras_err=%b required 1 123 1", jump_en, target, ras_err);
        end
        #2 reset = 1;
        #1;
        checks++;
        if (jump_en !== 0 || target !== 0 || running !== 0 || done !== 0 || ras_err !== 0) begin
            failures++;
            $display("FAIL async_reset jump_en=%b target=%h running=%b done=%b ras_err=%b required 0 000 0 0 0",
                     jump_en, target, running, done, ras_err);
        end
        @(posedge clk); @(negedge clk);
        reset = 0; clear_inputs(); model_reset(); set_pc(12'h050);
        eval_model(); #1;
        checks++;
        if (running !== 0 || done !== 0 || jump_en !== 1 || target !== 12'h050) begin
            failures++;
            $display("FAIL post_reset_idle running=%b done=%b jump_en=%b target=%h required 0 0 1 050",
                     running, done, jump_en, target);
        end
        step();
        start = 1; start_addr = 12'h100; eval_model(); step(); start = 0;
        ret = 1; eval_model(); #1;
        checks++;
        if (jump_en !== 1 || target !== 12'h100) begin
            failures++;
            $display("FAIL post_reset_empty jump_en=%b target=%h required 1 100", jump_en, target);
        end
        step(); ret = 0;
        eval_model(); #1;
        checks++;
        if (done !== 1 || ras_err !== 1) begin
            failures++;
            $display("FAIL post_reset_underflow done=%b ras_err=%b required 1 1", done, ras_err);
        end
        $display("async_reset: post-reset ret underflowed done=%b", done);
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            clear_inputs();
            start      = ($urandom_range(0, 99) < 4);
            start_addr = D'($urandom);
            halt       = ($urandom_range(0, 99) < 3);
            stall      = ($urandom_range(0, 99) < 12);
            ret        = ($urandom_range(0, 99) < 25);
            call       = ($urandom_range(0, 99) < 25);
            br_taken   = ($urandom_range(0, 99) < 35);
            br_rel     = 1'($urandom_range(0, 1));
            br_offset  = D'($urandom);
            br_addr    = D'($urandom);
            if ($urandom_range(0, 9) == 0) set_pc(D'($urandom));
            eval_model(); #1;
            checks++;
            if (jump_en !== exp_jump || (exp_jump && target !== exp_tgt) || running !== exp_run ||
                done !== exp_done || ras_err !== m_err) begin
                failures++;
                $display("FAIL random cyc=%0d jump_en=%b target=%h running=%b done=%b ras_err=%b required %b %h %b %b %b",
                         n, jump_en, target, running, done, ras_err, exp_jump, exp_tgt, exp_run, exp_done, m_err);
            end
            step();
        end
        clear_inputs();
        $display("random: 400 cycles compared");
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_start();
        test_branch();
        test_call_ret();
        test_overflow();
        test_stall_halt();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
